// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - segment patterns and digit-index sizing shared by display blocks
package bcd_disp_pkg;

   // Segment order is {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   // Width of a digit index; a single-digit display still needs a 1-bit index
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD to 7-segment decoder, dash for non-BCD codes
module seg7_decoder
   import bcd_disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Table lookup; codes 10..15 show a dash so corrupt counter values are visible
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - multiplexed 7-segment scan driver; BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking
module bcd_scan_display
   import bcd_disp_pkg::*;
#(
   parameter int                        NUM_DIGITS     = 3,
   parameter int                        SCAN_DIV_WIDTH = 16,
   parameter logic [SCAN_DIV_WIDTH-1:0] SCAN_DIV       = 16'd50000,
   parameter logic [SCAN_DIV_WIDTH-1:0] BLANK_CYCLES   = 16'd500
)(
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    disp_en,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_start
);

   localparam int                        IW       = idx_width(NUM_DIGITS);
   localparam logic [SCAN_DIV_WIDTH-1:0] CNT_LAST = SCAN_DIV - 1'b1;
   localparam logic [IW-1:0]             IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [SCAN_DIV_WIDTH-1:0] r_cnt;
   logic [IW-1:0]             r_idx;
   logic [4*NUM_DIGITS-1:0]   r_shadow;
   logic [6:0]                r_seg;
   logic [NUM_DIGITS-1:0]     r_dig_sel;
   logic                      r_frame_start;

   logic                      w_tick;
   logic                      w_frame_end;
   logic [3:0]                w_nibble;
   logic [6:0]                w_seg;
   logic [NUM_DIGITS-1:0]     w_dig_on;
   logic                      w_lz_blank;

   assign w_tick      = (r_cnt == CNT_LAST);
   assign w_frame_end = w_tick && (r_idx == IDX_LAST);
   assign w_dig_on    = ~(NUM_DIGITS'(1) << r_idx);

   // Select the snapshot nibble belonging to the digit currently being scanned
   always_comb begin
      w_nibble = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IW'(i)) w_nibble = r_shadow[4*i +: 4];
      end
   end

`ifdef BCD_SCAN_LZ_BLANK_EN
   // A digit above the units is dark when it and every higher digit are zero
   always_comb begin
      w_lz_blank = 1'b0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (r_idx == IW'(i)) w_lz_blank = ((r_shadow >> (4*i)) == '0);
      end
   end
`else
   assign w_lz_blank = 1'b0;
`endif

   seg7_decoder u_dec (
      .i_bcd (w_nibble),
      .o_seg (w_seg)
   );

   // Slot prescaler and digit index; index advances once per slot
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Whole-frame snapshot so a counter update never mixes two values in one frame
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shadow      <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_end;
         if (w_frame_end) r_shadow <= bcd_in;
      end
   end

   // Registered drive; the blanking window at each slot start prevents ghosting
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_seg     <= SEG_OFF;
         r_dig_sel <= '1;
      end else if (!disp_en || (r_cnt < BLANK_CYCLES) || w_lz_blank) begin
         r_seg     <= SEG_OFF;
         r_dig_sel <= '1;
      end else begin
         r_seg     <= w_seg;
         r_dig_sel <= w_dig_on;
      end
   end

   assign seg         = r_seg;
   assign dig_sel     = r_dig_sel;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display against a time-based reference model
module tb_bcd_scan_display;

   localparam int ND    = 3;
   localparam int SD    = 4;
   localparam int BL    = 1;
   localparam int FRAME = ND * SD;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        disp_en   = 1'b0;
   logic [11:0] bcd_in    = 12'h000;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;
   logic        frame_start;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: cycles since reset release and the model's own frame snapshot
   int          t        = 0;
   logic [11:0] m_shadow = 12'h000;
   logic [10:0] exp_q[$];

   bcd_scan_display #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV_WIDTH (16),
      .SCAN_DIV       (16'd4),
      .BLANK_CYCLES   (16'd1)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .disp_en     (disp_en),
      .bcd_in      (bcd_in),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .frame_start (frame_start)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b1000000;
      endcase
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0d: got seg=%b dig_sel=%b frame_start=%b, want seg=%b dig_sel=%b frame_start=%b",
                    name, t, act[10:4], act[3:1], act[0], exp[10:4], exp[3:1], exp[0]);
   endtask

   // Called at a negedge: predict the outputs after the coming posedge, then advance one cycle
   task automatic step();
      int          cnt;
      int          idx;
      int          nib;
      bit          blank;
      bit          fs;
      logic [6:0]  e_seg;
      logic [2:0]  e_dig;
      cnt   = t % SD;
      idx   = (t / SD) % ND;
      nib   = int'((m_shadow >> (4*idx)) & 12'hF);
      blank = !disp_en || (cnt < BL);
`ifdef BCD_SCAN_LZ_BLANK_EN
      if (idx >= 1 && (m_shadow >> (4*idx)) == 12'h000) blank = 1'b1;
`endif
      fs = ((t % FRAME) == FRAME - 1);
      if (blank) begin
         e_seg = 7'b0000000;
         e_dig = 3'b111;
      end else begin
         e_seg = ref_seg(nib);
         e_dig = 3'b111 & ~(3'b001 << idx);
      end
      exp_q.push_back({e_seg, e_dig, fs});
      if (fs) m_shadow = bcd_in;
      t++;
      @(negedge sys_clk);
   endtask

   task automatic model_reset();
      t        = 0;
      m_shadow = 12'h000;
      exp_q.delete();
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      check("reset_state", {seg, dig_sel, frame_start}, {7'b0000000, 3'b111, 1'b0});
      sys_rst_n = 1'b1;
      model_reset();
   endtask

   // Reset asserted between clock edges; outputs must clear without waiting for a clock
   task automatic async_reset();
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("async_reset", {seg, dig_sel, frame_start}, {7'b0000000, 3'b111, 1'b0});
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: every post-reset clock produces one output word to score
   initial begin
      logic [10:0] e;
      forever begin
         @(posedge sys_clk);
         #1;
         if (sys_rst_n) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL scoreboard_empty t=%0d: got output with no expectation queued", t);
            end else begin
               e = exp_q.pop_front();
               check("scan", {seg, dig_sel, frame_start}, e);
            end
         end
      end
   end

   initial begin
      @(negedge sys_clk);
      do_reset();

      // Steady value 149 across several frames
      bcd_in  = 12'h149;
      disp_en = 1'b1;
      repeat (2*FRAME + 3) step();

      // Change during the tens slot; the frame in progress must stay 149
      while ((t % FRAME) != 5) step();
      bcd_in = 12'h023;
      repeat (2*FRAME) step();

      // Non-BCD tens nibble
      bcd_in = 12'h0A5;
      repeat (2*FRAME) step();

      // Display disable pulse of 6 cycles
      while ((t % FRAME) != 2) step();
      disp_en = 1'b0;
      repeat (6) step();
      disp_en = 1'b1;
      repeat (2*FRAME) step();

      // Async reset while frame_start is high, then restart timing
      while ((t % FRAME) != 0) step();
      async_reset();
      repeat (2*FRAME) step();

      // Leading zeros
      bcd_in = 12'h007;
      repeat (3*FRAME) step();

      // Randomized traffic with occasional mid-slot resets
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(7) == 0) bcd_in = 12'($urandom);
         if ($urandom_range(15) == 0) disp_en = ~disp_en;
         if (k == 200 || k == 451) async_reset();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
